// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 widths, key-cache FSM states and round-key ordering helper.
package sm4_encryptor_pkg;

  localparam int unsigned KeyWidth   = 128;
  localparam int unsigned NumRounds  = 32;
  localparam int unsigned RkWidth    = 32;
  localparam int unsigned RkBusWidth = NumRounds * RkWidth;

  typedef enum logic [2:0] {
    StIdle,
    StCmp,
    StReq,
    StWait,
    StResp
  } cache_state_e;

  // Decode uses the round keys in reverse order.
  function automatic logic [RkBusWidth-1:0] order_rk(input logic [RkBusWidth-1:0] rk,
                                                     input logic               decode);
    logic [RkBusWidth-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < NumRounds; i++) begin
      res[i*RkWidth +: RkWidth] = decode ? rk[(NumRounds-1-i)*RkWidth +: RkWidth]
                                         : rk[i*RkWidth +: RkWidth];
    end
    return res;
  endfunction

endpackage

// File: rtl/sm4_key_cache_if.sv
// Lookup, result and key-expander handshakes of the SM4 round-key cache.
interface sm4_key_cache_if #(
  parameter int unsigned ways_p = 4
);
  import sm4_encryptor_pkg::*;

  localparam int unsigned WayW = $clog2(ways_p);

  logic                  lkp_v_i;
  logic                  lkp_ready_o;
  logic [KeyWidth-1:0]   lkp_key_i;
  logic                  lkp_decode_i;
  logic                  rk_v_o;
  logic                  rk_yumi_i;
  logic [RkBusWidth-1:0] rk_o;
  logic                  hit_o;
  logic [WayW-1:0]       way_o;
  logic                  exp_v_o;
  logic                  exp_ready_i;
  logic [KeyWidth-1:0]   exp_key_o;
  logic                  exp_rk_v_i;
  logic [RkBusWidth-1:0] exp_rk_i;

  modport slave (
    input  lkp_v_i, lkp_key_i, lkp_decode_i, rk_yumi_i, exp_ready_i, exp_rk_v_i, exp_rk_i,
    output lkp_ready_o, rk_v_o, rk_o, hit_o, way_o, exp_v_o, exp_key_o
  );

  modport master (
    output lkp_v_i, lkp_key_i, lkp_decode_i, rk_yumi_i, exp_ready_i, exp_rk_v_i, exp_rk_i,
    input  lkp_ready_o, rk_v_o, rk_o, hit_o, way_o, exp_v_o, exp_key_o
  );

endinterface

// File: rtl/sm4_cache_victim_sel.sv
// Victim way: lowest-index invalid way, otherwise the round-robin pointer.
module sm4_cache_victim_sel #(
  parameter int unsigned ways_p = 4
) (
  input  logic [ways_p-1:0]         valid_i,
  input  logic [$clog2(ways_p)-1:0] ptr_i,
  output logic [$clog2(ways_p)-1:0] victim_o,
  output logic                      all_valid_o
);

  localparam int unsigned WayW = $clog2(ways_p);

  always_comb begin
    victim_o    = ptr_i;
    all_valid_o = &valid_i;
    // Scan downwards so the lowest invalid index is written last.
    for (int i = ways_p - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        victim_o = WayW'(i);
      end
    end
  end

endmodule

// File: rtl/sm4_key_cache.sv
// Fully-associative cache of SM4 expanded round keys in front of an external expander.
module sm4_key_cache
  import sm4_encryptor_pkg::*;
#(
  parameter int unsigned ways_p      = 4,
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_n_i,
  sm4_key_cache_if.slave         bus,
  input  logic                   invalid_cache_i,
  output logic [cnt_width_p-1:0] hit_cnt_o,
  output logic [cnt_width_p-1:0] miss_cnt_o
);

  localparam int unsigned WayW = $clog2(ways_p);

  cache_state_e          state_q, state_d;
  logic [KeyWidth-1:0]   key_q, key_d;
  logic                  decode_q, decode_d;
  logic [KeyWidth-1:0]   tag_q [ways_p];
  logic [KeyWidth-1:0]   tag_d [ways_p];
  logic [RkBusWidth-1:0] data_q [ways_p];
  logic [RkBusWidth-1:0] data_d [ways_p];
  logic [ways_p-1:0]     valid_q, valid_d;
  logic [WayW-1:0]       ptr_q, ptr_d;
  logic [RkBusWidth-1:0] rk_q, rk_d;
  logic                  hit_q, hit_d;
  logic [WayW-1:0]       way_q, way_d;
  logic [cnt_width_p-1:0] hit_cnt_q, hit_cnt_d;
  logic [cnt_width_p-1:0] miss_cnt_q, miss_cnt_d;

  logic                  lookup_hit;
  logic [WayW-1:0]       hit_way;
  logic [WayW-1:0]       victim_way;
  logic                  all_valid;

  sm4_cache_victim_sel #(
    .ways_p(ways_p)
  ) u_victim_sel (
    .valid_i    (valid_q),
    .ptr_i      (ptr_q),
    .victim_o   (victim_way),
    .all_valid_o(all_valid)
  );

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int unsigned w = 0; w < ways_p; w++) begin
      if (valid_q[w] && (tag_q[w] == key_q)) begin
        lookup_hit = 1'b1;
        hit_way    = WayW'(w);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    key_d      = key_q;
    decode_d   = decode_q;
    tag_d      = tag_q;
    data_d     = data_q;
    valid_d    = valid_q;
    ptr_d      = ptr_q;
    rk_d       = rk_q;
    hit_d      = hit_q;
    way_d      = way_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;

    // Invalidation clears first so a same-cycle fill below still lands valid.
    if (invalid_cache_i) begin
      valid_d = '0;
      ptr_d   = '0;
    end

    unique case (state_q)
      StIdle: begin
        if (bus.lkp_v_i) begin
          key_d    = bus.lkp_key_i;
          decode_d = bus.lkp_decode_i;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        if (lookup_hit) begin
          rk_d  = order_rk(data_q[hit_way], decode_q);
          hit_d = 1'b1;
          way_d = hit_way;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + cnt_width_p'(1);
          state_d = StResp;
        end else begin
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + cnt_width_p'(1);
          state_d = StReq;
        end
      end
      StReq: begin
        if (bus.exp_ready_i) state_d = StWait;
      end
      StWait: begin
        if (bus.exp_rk_v_i) begin
          tag_d[victim_way]   = key_q;
          data_d[victim_way]  = bus.exp_rk_i;
          valid_d[victim_way] = 1'b1;
          if (all_valid && !invalid_cache_i) ptr_d = ptr_q + WayW'(1);
          rk_d    = order_rk(bus.exp_rk_i, decode_q);
          hit_d   = 1'b0;
          way_d   = victim_way;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rk_yumi_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= StIdle;
      key_q      <= '0;
      decode_q   <= 1'b0;
      valid_q    <= '0;
      ptr_q      <= '0;
      rk_q       <= '0;
      hit_q      <= 1'b0;
      way_q      <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      for (int unsigned w = 0; w < ways_p; w++) begin
        tag_q[w]  <= '0;
        data_q[w] <= '0;
      end
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      decode_q   <= decode_d;
      valid_q    <= valid_d;
      ptr_q      <= ptr_d;
      rk_q       <= rk_d;
      hit_q      <= hit_d;
      way_q      <= way_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      tag_q      <= tag_d;
      data_q     <= data_d;
    end
  end

  assign bus.lkp_ready_o = (state_q == StIdle);
  assign bus.exp_v_o     = (state_q == StReq);
  assign bus.exp_key_o   = key_q;
  assign bus.rk_v_o      = (state_q == StResp);
  assign bus.rk_o        = rk_q;
  assign bus.hit_o       = hit_q;
  assign bus.way_o       = way_q;
  assign hit_cnt_o       = hit_cnt_q;
  assign miss_cnt_o      = miss_cnt_q;

endmodule
